// File: rtl/feature_stream_loader.sv
// Serial-to-tile loader: gathers PRECISION-bit elements into NUM_FEATURES x N tiles
// and hands them downstream through a two-deep ping-pong buffer.
module feature_stream_loader #(
  parameter int PRECISION    = 8,
  parameter int NUM_FEATURES = 2,
  parameter int N            = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          ce,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [PRECISION-1:0]                          s_data,
  input  logic                                          s_last,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] features,
  output logic                                          frame_err,
  output logic [1:0]                                    occupancy
);

  localparam int TOTAL = NUM_FEATURES * N;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

  // Handshakes: a transfer happens on a rising edge only when valid, ready and ce
  // are all 1; ready never depends combinationally on the opposite side's valid/ready.
  logic [1:0][TOTAL-1:0][PRECISION-1:0] tiles;
  logic                                 wp;
  logic                                 rp;
  logic [IW-1:0]                        idx;
  logic [1:0]                           cnt;
  logic                                 in_xfer;
  logic                                 out_xfer;
  logic                                 at_end;
  logic                                 commit;

  assign s_ready   = (cnt < 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign occupancy = cnt;
  assign features  = tiles[rp];

  always_comb begin
    in_xfer  = s_valid & s_ready & ce;
    out_xfer = out_valid & out_ready & ce;
    at_end   = (idx == LAST_IDX);
    commit   = in_xfer & (at_end | s_last);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tiles     <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      idx       <= '0;
      cnt       <= 2'd0;
      frame_err <= 1'b0;
    end else begin
      if (in_xfer) begin
        // The first element of a tile wipes its buffer so short tiles never expose stale data.
        if (idx == '0) tiles[wp] <= '0;
        tiles[wp][idx] <= s_data;
        idx <= commit ? '0 : idx + IW'(1);
      end
      if (commit) begin
        wp <= ~wp;
        if (!(at_end && s_last)) frame_err <= 1'b1;
      end
      if (out_xfer) rp <= ~rp;
      if (commit && !out_xfer)      cnt <= cnt + 2'd1;
      else if (!commit && out_xfer) cnt <= cnt - 2'd1;
    end
  end

endmodule
